fb_scan_arbiter: RTL and testbench

FB_SCAN_ARBITER -- requirements
Module: fb_scan_arbiter

---
 rtl/fb_scan_arbiter.sv | 159 +++++++++++++++
 tb/tb_fb_scan_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_arbiter.sv
// Framebuffer port arbiter for scanline fetch versus drawing writes.
//
// On each line pulse whose sy lies in [-1, V_RES-2] the block fetches line
// T = sy+1 from the single-port framebuffer into a double-banked line buffer
// (bank = T[0]). The fetch takes the memory port for H_RES consecutive
// cycles starting the cycle after the trigger. The drawing engine gets the
// port whenever scanout does not need it. A trigger that arrives while a
// fetch is still in flight sets the sticky overrun flag and restarts the
// fetch for the new line.
//
// Ports:
//   clk_pix, rst_pix_n      pixel clock, async active-low reset
//   line, sy                line-start pulse and current (signed) line
//   draw_req/addr/data      drawing engine write request
//   draw_gnt                write accepted when draw_req && draw_gnt
//   mem_addr/we/wdata       framebuffer port (mem_rdata: 1-cycle latency)
//   lb_we/bank/addr/data    line buffer write port
//   fetch_done              pulse with the last line buffer write of a line
//   overrun                 sticky: fetch restarted before completion
module fb_scan_arbiter #(
  parameter int unsigned CORDW = 16,
  parameter int unsigned H_RES = 24,
  parameter int unsigned V_RES = 18,
  parameter int unsigned ADDRW = 9,
  parameter int unsigned DATAW = 4
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix_n,
  input  logic                       line,
  input  logic signed [CORDW-1:0]    sy,
  input  logic                       draw_req,
  input  logic [ADDRW-1:0]           draw_addr,
  input  logic [DATAW-1:0]           draw_data,
  output logic                       draw_gnt,
  output logic [ADDRW-1:0]           mem_addr,
  output logic                       mem_we,
  output logic [DATAW-1:0]           mem_wdata,
  input  logic [DATAW-1:0]           mem_rdata,
  output logic                       lb_we,
  output logic                       lb_bank,
  output logic [$clog2(H_RES)-1:0]   lb_addr,
  output logic [DATAW-1:0]           lb_data,
  output logic                       fetch_done,
  output logic                       overrun
);

  localparam int unsigned CntW = $clog2(H_RES);

  localparam logic signed [CORDW-1:0] SyMin   = '1;  // -1
  localparam logic signed [CORDW-1:0] SyMax   = CORDW'(V_RES - 2);
  localparam logic [ADDRW-1:0]        HResA   = ADDRW'(H_RES);
  localparam logic [CntW-1:0]         CntLast = CntW'(H_RES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDRW-1:0]  base_q, base_d;
  logic              bank_q, bank_d;
  logic              overrun_q, overrun_d;

  // Read-return pipeline: one entry per issued read, consumed next cycle.
  logic              rd_vld_q, rd_vld_d;
  logic [CntW-1:0]   rd_idx_q, rd_idx_d;
  logic              rd_bank_q, rd_bank_d;

  logic              trigger;
  logic [ADDRW-1:0]  tgt;

  // Target line in address width; sy = -1 wraps cleanly to line 0.
  assign trigger = line && (sy >= SyMin) && (sy <= SyMax);
  assign tgt     = ADDRW'(sy) + ADDRW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    bank_d    = bank_q;
    overrun_d = overrun_q;

    if (trigger) begin
      // Any trigger outside IDLE means the previous fetch was cut short.
      if (state_q != StIdle) begin
        overrun_d = 1'b1;
      end
      state_d = StFetch;
      cnt_d   = '0;
      base_d  = tgt * HResA;
      bank_d  = tgt[0];
    end else begin
      case (state_q)
        StFetch: begin
          if (cnt_q == CntLast) begin
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDrain: state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_vld_d  = (state_q == StFetch);
    rd_idx_d  = cnt_q;
    rd_bank_d = bank_q;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      base_q    <= '0;
      bank_q    <= 1'b0;
      overrun_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      bank_q    <= bank_d;
      overrun_q <= overrun_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Scanout always wins: a trigger this cycle blocks drawing immediately.
  // Reset gating keeps the grant low while the block is held in reset.
  always_comb begin
    draw_gnt  = rst_pix_n && (state_q != StFetch) && !trigger;
    mem_we    = draw_req && draw_gnt;
    mem_wdata = draw_data;
    if (state_q == StFetch) begin
      mem_addr = base_q + ADDRW'(cnt_q);
    end else begin
      mem_addr = draw_addr;
    end
  end

  always_comb begin
    lb_we      = rd_vld_q;
    lb_addr    = rd_idx_q;
    lb_bank    = rd_bank_q;
    lb_data    = mem_rdata;
    fetch_done = rd_vld_q && (rd_idx_q == CntLast);
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
module tb_fb_scan_arbiter;

  localparam int CORDW = 16;
  localparam int H_RES = 24;
  localparam int V_RES = 18;
  localparam int ADDRW = 9;
  localparam int DATAW = 4;
  localparam int LBW   = $clog2(H_RES);
  localparam int NCYC  = 4096;
  localparam int MEMD  = 1 << ADDRW;

  logic                     clk_pix;
  logic                     rst_pix_n;
  logic                     line;
  logic signed [CORDW-1:0]  sy;
  logic                     draw_req;
  logic [ADDRW-1:0]         draw_addr;
  logic [DATAW-1:0]         draw_data;
  logic                     draw_gnt;
  logic [ADDRW-1:0]         mem_addr;
  logic                     mem_we;
  logic [DATAW-1:0]         mem_wdata;
  logic [DATAW-1:0]         mem_rdata;
  logic                     lb_we;
  logic                     lb_bank;
  logic [LBW-1:0]           lb_addr;
  logic [DATAW-1:0]         lb_data;
  logic                     fetch_done;
  logic                     overrun;

  fb_scan_arbiter #(
    .CORDW (CORDW),
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDRW (ADDRW),
    .DATAW (DATAW)
  ) dut (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .line       (line),
    .sy         (sy),
    .draw_req   (draw_req),
    .draw_addr  (draw_addr),
    .draw_data  (draw_data),
    .draw_gnt   (draw_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .lb_we      (lb_we),
    .lb_bank    (lb_bank),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data),
    .fetch_done (fetch_done),
    .overrun    (overrun)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // Framebuffer: synchronous single-port RAM, read data one cycle later.
  logic [DATAW-1:0] mem [MEMD];
  always @(posedge clk_pix) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model: a per-cycle schedule of expected port reads and line
  // buffer writes, plus a shadow copy of the framebuffer contents.
  int               exp_raddr  [NCYC];
  int               exp_lbidx  [NCYC];
  int               exp_lbbank [NCYC];
  int               exp_lbdata [NCYC];
  logic [DATAW-1:0] refmem     [MEMD];
  bit               ovr;
  int               cyc;
  int               errors;
  int               checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_sched(input int from);
    for (int i = from; i < NCYC; i++) begin
      exp_raddr[i] = -1;
      exp_lbidx[i] = -1;
    end
  endtask

  task automatic drive(input bit ln, input int s, input bit rq);
    line      = ln;
    sy        = CORDW'(s);
    draw_req  = rq;
    draw_addr = ADDRW'($urandom);
    draw_data = DATAW'($urandom);
  endtask

  // Called at posedge+1 with inputs applied; samples mid-cycle, advances.
  task automatic run_cycle();
    int s, raddr, lbi, base, t;
    bit trig, busy, lbs, gnt, we;
    s     = sy;
    trig  = line && (s >= -1) && (s <= V_RES - 2);
    raddr = exp_raddr[cyc];
    lbi   = exp_lbidx[cyc];
    busy  = (raddr >= 0);
    lbs   = (lbi >= 0);
    gnt   = !busy && !trig;
    we    = gnt && draw_req;
    #4;
    check("draw_gnt", 32'(draw_gnt), 32'(gnt));
    check("mem_we", 32'(mem_we), 32'(we));
    if (busy) begin
      check("mem_addr_fetch", 32'(mem_addr), 32'(raddr));
    end else begin
      check("mem_addr_draw", 32'(mem_addr), 32'(draw_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(draw_data));
    end
    check("lb_we", 32'(lb_we), 32'(lbs));
    if (lbs) begin
      check("lb_addr", 32'(lb_addr), 32'(lbi));
      check("lb_bank", 32'(lb_bank), 32'(exp_lbbank[cyc]));
      check("lb_data", 32'(lb_data), 32'(exp_lbdata[cyc]));
    end
    check("fetch_done", 32'(fetch_done), 32'(lbs && (lbi == H_RES - 1)));
    check("overrun", 32'(overrun), 32'(ovr));

    if (busy && cyc + 1 < NCYC) exp_lbdata[cyc + 1] = int'(refmem[raddr]);
    if (we) refmem[draw_addr] = draw_data;
    if (trig) begin
      if (busy || lbs) ovr = 1'b1;
      t    = s + 1;
      base = t * H_RES;
      for (int k = 0; k < H_RES; k++) begin
        if (cyc + 2 + k < NCYC) begin
          exp_raddr[cyc + 1 + k]  = base + k;
          exp_lbidx[cyc + 2 + k]  = k;
          exp_lbbank[cyc + 2 + k] = t % 2;
        end
      end
    end
    @(posedge clk_pix);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rand_req);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, rand_req ? 1'($urandom_range(0, 1)) : 1'b0);
      run_cycle();
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    ovr       = 1'b0;
    rst_pix_n = 1'b0;
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < MEMD; i++) begin
      mem[i]    = DATAW'(i % 16);
      refmem[i] = DATAW'(i % 16);
    end
    clear_sched(0);

    // Held in reset: everything quiet, drawing not granted.
    #2;
    check("rst_draw_gnt", 32'(draw_gnt), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_lb_we", 32'(lb_we), 32'(0));
    check("rst_fetch_done", 32'(fetch_done), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    check("rst_lb_bank", 32'(lb_bank), 32'(0));
    repeat (2) @(posedge clk_pix);
    #1;
    rst_pix_n = 1'b1;

    // Line 0 fetch from sy = -1, first trigger after release.
    drive(1'b1, -1, 1'b0);
    run_cycle();
    idle(30, 1'b0);

    // Line 5 fetch (base 120, bank 1) with random draw traffic around it.
    drive(1'b1, 4, 1'b1);
    run_cycle();
    idle(30, 1'b1);

    // Drawing held high across a fetch: grant only outside FETCH.
    drive(1'b1, 0, 1'b1);
    run_cycle();
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 0, 1'b1);
      run_cycle();
    end

    // Out-of-range line pulses are ignored.
    drive(1'b1, 17, 1'b1);
    run_cycle();
    drive(1'b0, 0, 1'b1);
    run_cycle();
    drive(1'b1, -5, 1'b1);
    run_cycle();
    drive(1'b1, 40, 1'b1);
    run_cycle();
    idle(3, 1'b1);

    // Overrun: second trigger 10 cycles after the first, then clean lines.
    drive(1'b1, 2, 1'b0);
    run_cycle();
    idle(9, 1'b1);
    drive(1'b1, 3, 1'b0);
    run_cycle();
    idle(30, 1'b1);
    drive(1'b1, 5, 1'b0);
    run_cycle();
    idle(30, 1'b1);

    // Trigger exactly in DRAIN.
    drive(1'b1, 8, 1'b0);
    run_cycle();
    idle(H_RES, 1'b1);
    drive(1'b1, 9, 1'b0);
    run_cycle();
    idle(30, 1'b1);

    // Random line pulses, spacing and drawing traffic.
    for (int n = 0; n < 40; n++) begin
      drive(1'b1, int'($urandom_range(0, V_RES + 7)) - 6, 1'($urandom_range(0, 1)));
      run_cycle();
      idle(int'($urandom_range(0, 30)), 1'b1);
    end
    idle(30, 1'b1);

    // Reset mid-fetch at cnt = 12: outputs drop at once, no stray writes.
    drive(1'b1, 6, 1'b0);
    run_cycle();
    idle(12, 1'b0);
    drive(1'b0, 0, 1'b1);
    rst_pix_n = 1'b0;
    #1;
    check("mid_rst_draw_gnt", 32'(draw_gnt), 32'(0));
    check("mid_rst_mem_we", 32'(mem_we), 32'(0));
    check("mid_rst_lb_we", 32'(lb_we), 32'(0));
    check("mid_rst_fetch_done", 32'(fetch_done), 32'(0));
    check("mid_rst_overrun", 32'(overrun), 32'(0));
    check("mid_rst_lb_bank", 32'(lb_bank), 32'(0));
    clear_sched(cyc);
    ovr = 1'b0;
    repeat (2) @(posedge clk_pix);
    #1;
    rst_pix_n = 1'b1;
    idle(30, 1'b1);
    drive(1'b1, 7, 1'b0);
    run_cycle();
    idle(30, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
